seg7_scan_ctrl: RTL and testbench

Scan controller for a 4-digit, common-segment 7-segment display. It time-multiplexes one shared Segment bus across four digit enables, inserts blanking between digits to prevent ghosting, and double-buffers new display data. Updates from upstream are applied only at frame boundaries, so a digit never tears mid-scan. It sits between the counter/status logic and the board-level Segment/AN pins.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_hex_decode.sv | 19 +
 rtl/seg7_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared definitions for the 4-digit 7-segment scan controller.
//               Contents:
//                 - hex-to-segment lookup table (bit order g..a)
//                 - digit count
//                 - scan FSM state type
//                 - digit slot length helper
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Number of multiplexed digits on the shared segment bus.
    localparam int DIGITS = 4;

    // Active-high segment patterns, index = hex nibble, bits [6:0] = g..a.
    // Lower-case b and d keep them distinct from 8 and 0.
    localparam logic [6:0] c_hex_table [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Clocks per digit slot; integer division truncates.
    function automatic int unsigned digit_cycles(input int unsigned clk_freq,
                                                 input int unsigned scan_hz);
        return clk_freq / scan_hz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decode
// Description : Combinational hex nibble to 7-segment pattern decoder.
// Ports       : nibble  in  [3:0]  hex value to display
//               seg     out [6:0]  active-high segments g..a
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = c_hex_table[nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Scan controller for a 4-digit common-segment 7-segment
//               display. It time-multiplexes the segment bus across the four
//               digit enables and blanks the start of every slot to avoid
//               ghosting. New data is double-buffered: it is loaded into a
//               shadow register and copied to the active register only at
//               the end of the digit-3 slot, so a frame never tears.
// Ports       : CLK          in       system clock, rising edge
//               RST          in       asynchronous active-high reset
//               load         in       one-cycle capture strobe for new data
//               digits_in    in  [15:0] four hex nibbles, [3:0] = digit 0
//               dp_in        in  [3:0]  decimal point per digit, 1 = lit
//               blank_in     in  [3:0]  per-digit blank, 1 = dark
//               Segment      out [7:0]  [6:0] = g..a, [7] = dp, active high
//               AN           out [3:0]  one-hot digit enable, 0 when dark
//               pending      out      shadow data waiting for frame end
//               upd_done     out      pulse when shadow becomes active
//               frame_pulse  out      pulse on last clock of digit-3 slot
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 125_000_000,
    parameter int unsigned SCAN_HZ      = 1000,
    parameter int unsigned BLANK_CYCLES = 125
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [7:0]  Segment,
    output logic [3:0]  AN,
    output logic        pending,
    output logic        upd_done,
    output logic        frame_pulse
);

    localparam logic [31:0] c_digit_cycles = 32'(digit_cycles(CLK_FREQ, SCAN_HZ));
    localparam logic [31:0] c_last_cnt     = c_digit_cycles - 32'd1;
    localparam logic [31:0] c_blank_cycles = 32'(BLANK_CYCLES);
    localparam logic [1:0]  c_last_idx     = 2'(DIGITS - 1);

    // Scan position
    logic [31:0]  r_cnt;
    logic [1:0]   r_idx;
    scan_state_t  r_state;

    // Active (displayed) and shadow (staged) display data
    logic [15:0]  r_act_digits;
    logic [3:0]   r_act_dp;
    logic [3:0]   r_act_blank;
    logic [15:0]  r_sh_digits;
    logic [3:0]   r_sh_dp;
    logic [3:0]   r_sh_blank;

    logic         w_boundary;
    logic         w_blank_phase;
    logic         w_dark;
    logic [3:0]   w_nibble;
    logic [6:0]   w_seg;

    assign w_boundary    = (r_idx == c_last_idx) && (r_cnt == c_last_cnt);
    assign w_blank_phase = (r_cnt < c_blank_cycles);
    // A blanked digit keeps its slot timing but never lights.
    assign w_dark        = w_blank_phase || r_act_blank[r_idx];
    assign w_nibble      = r_act_digits[{r_idx, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .nibble (w_nibble),
        .seg    (w_seg)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_state      <= ST_BLANK;
            Segment      <= '0;
            AN           <= '0;
            pending      <= 1'b0;
            upd_done     <= 1'b0;
            frame_pulse  <= 1'b0;
            r_act_digits <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= 4'b1111;
            r_sh_digits  <= '0;
            r_sh_dp      <= '0;
            r_sh_blank   <= 4'b1111;
        end else begin
            // Slot counter and digit index
            if (r_cnt == c_last_cnt) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end

            // State tracks the phase of the slot position being output
            if (r_state == ST_BLANK) begin
                if (!w_blank_phase) begin
                    r_state <= ST_DRIVE;
                end
            end else begin
                if (w_blank_phase) begin
                    r_state <= ST_BLANK;
                end
            end

            // Registered outputs: one clock behind the scan position
            if (w_dark) begin
                AN      <= 4'b0000;
                Segment <= 8'h00;
            end else begin
                AN      <= 4'b0001 << r_idx;
                Segment <= {r_act_dp[r_idx], w_seg};
            end

            frame_pulse <= w_boundary;
            upd_done    <= w_boundary && pending;

            // The copy uses the shadow as it stood before this clock, so a
            // load landing on the boundary waits for the following frame.
            if (w_boundary && pending) begin
                r_act_digits <= r_sh_digits;
                r_act_dp     <= r_sh_dp;
                r_act_blank  <= r_sh_blank;
            end

            if (load) begin
                r_sh_digits <= digits_in;
                r_sh_dp     <= dp_in;
                r_sh_blank  <= blank_in;
                pending     <= 1'b1;
            end else if (w_boundary) begin
                pending     <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Self-checking bench for seg7_scan_ctrl with a 10-clock slot,
//               2 blank clocks and a 40-clock frame. Loads expected to be
//               applied push a display record; a monitor checks every output
//               cycle against the current record and pops the next record
//               whenever upd_done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int DC = 10;
    localparam int BC = 2;
    localparam int FR = 40;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [7:0]  Segment;
    logic [3:0]  AN;
    logic        pending;
    logic        upd_done;
    logic        frame_pulse;

    seg7_scan_ctrl #(
        .CLK_FREQ     (1000),
        .SCAN_HZ      (100),
        .BLANK_CYCLES (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .load        (load),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .Segment     (Segment),
        .AN          (AN),
        .pending     (pending),
        .upd_done    (upd_done),
        .frame_pulse (frame_pulse)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic        pend_after;
    } rec_t;

    localparam rec_t c_dark = '{d: 16'h0000, dp: 4'h0, bl: 4'hF, pend_after: 1'b0};

    logic [6:0] tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    rec_t q[$];
    rec_t cur;
    int   total = 0;
    int   bad = 0;
    int   edges = 0;

    // Monitor scratch
    int         m_pos, m_slot, m_c;
    logic       m_lit, m_efp, m_eud;
    logic [3:0] m_ean, m_nib;
    logic [7:0] m_eseg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: {AN, Segment, frame_pulse, upd_done} every cycle
    initial begin
        cur = c_dark;
        forever begin
            @(posedge CLK);
            #1;
            if (RST) begin
                edges = 0;
                cur   = c_dark;
            end else begin
                edges++;
                m_pos  = (edges - 1) % FR;
                m_slot = m_pos / DC;
                m_c    = m_pos % DC;
                m_lit  = (m_c >= BC) && !cur.bl[m_slot];
                m_nib  = cur.d[m_slot*4 +: 4];
                m_ean  = m_lit ? 4'(1 << m_slot) : 4'h0;
                m_eseg = m_lit ? {cur.dp[m_slot], tbl[m_nib]} : 8'h00;
                m_efp  = (m_pos == FR - 1);
                m_eud  = m_efp && (q.size() > 0);
                chk("scan{AN,Seg,fp,upd}", 32'({AN, Segment, frame_pulse, upd_done}),
                    32'({m_ean, m_eseg, m_efp, m_eud}));
                if (upd_done && q.size() > 0) begin
                    cur = q.pop_front();
                    chk("pending_at_upd", 32'(pending), 32'(cur.pend_after));
                end
            end
        end
    end

    // Wait for the negedge where the outputs show frame position p
    task automatic goto(input int p);
        int n;
        n = 0;
        @(negedge CLK);
        while (((edges - 1) % FR) != p) begin
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL goto_timeout: got no position %0d expected within 200 cycles", p);
                return;
            end
            @(negedge CLK);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                           input bit push, input bit pend_after);
        digits_in = d;
        dp_in     = dp;
        blank_in  = bl;
        load      = 1'b1;
        if (push) q.push_back('{d: d, dp: dp, bl: bl, pend_after: pend_after});
        @(negedge CLK);
        load      = 1'b0;
        digits_in = ~d;
        dp_in     = ~dp;
        blank_in  = ~bl;
        chk("pending_after_load", 32'(pending), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected before 200000");
        $fatal(1);
    end

    initial begin
        #2 RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("reset_state", 32'({Segment, AN, pending, upd_done, frame_pulse}), 32'd0);
        RST = 1'b0;

        // 1: free run, display dark, frame pulse every 40 clocks
        repeat (80) @(negedge CLK);
        chk("pending_idle", 32'(pending), 32'd0);

        // 2: single update, shows F1 77 5B 06
        goto(5);
        do_load(16'h12AF, 4'b0001, 4'b0000, 1, 0);
        repeat (80) @(negedge CLK);

        // 3: two loads in one frame, only the last is shown
        goto(5);
        do_load(16'h1111, 4'b0000, 4'b0000, 0, 0);
        goto(20);
        do_load(16'h2222, 4'b0000, 4'b0000, 1, 0);
        repeat (80) @(negedge CLK);

        // 4: load on the frame boundary while pending
        goto(5);
        do_load(16'h3333, 4'b0000, 4'b0000, 1, 1);
        goto(38);
        do_load(16'h4444, 4'b0000, 4'b0000, 1, 0);
        repeat (90) @(negedge CLK);

        // 5: per-digit blanking
        goto(5);
        do_load(16'h8888, 4'b0000, 4'b1010, 1, 0);
        repeat (80) @(negedge CLK);

        // 6: remaining hex codes, then reset mid-frame with pending data
        goto(5);
        do_load(16'hBCD0, 4'b0100, 4'b0000, 1, 0);
        goto(5);
        do_load(16'h567E, 4'b1000, 4'b0000, 1, 0);
        goto(5);
        do_load(16'h9999, 4'b0000, 4'b0000, 0, 0);
        goto(14);
        chk("pre_reset_AN", 32'(AN), 32'h2);
        chk("pre_reset_Seg", 32'(Segment), 32'h27);
        RST = 1'b1;
        #1;
        chk("async_reset", 32'({Segment, AN, pending, upd_done, frame_pulse}), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (50) @(negedge CLK);
        chk("pending_after_reset", 32'(pending), 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
